// File: rtl/i2c_byte_master.sv
// ---------------------------------------------------------------------------
// i2c_byte_master
//
// Byte-level I2C master engine. Sits between the RTC controller and the
// RTC_SCL / RTC_SDA open-drain pads. Each accepted command runs one bus
// primitive:
//   00 START (also usable as a repeated START after a byte)
//   01 STOP
//   10 WRITE one byte, MSB first, then capture the slave ACK bit
//   11 READ one byte, MSB first, then send ACK (rd_nack=0) or NACK (rd_nack=1)
//
// Every primitive is built from bit slots. Each slot has four quarter-bit
// phases A, B, C, D, and each phase lasts CLK_DIV cycles of clk14. While
// SCL is released, a slave may hold it low to stretch the clock. That
// stretching is bounded by STRETCH_MAX cycles. When the bound is reached,
// the command aborts, both lines are released and timeout is raised.
//
// Ports:
//   clk14      system clock (14.318 MHz)
//   reset_n    synchronous, active-low reset; releases both lines, no STOP
//   cmd_valid  command request
//   cmd_ready  engine idle; a command is taken when cmd_valid && cmd_ready
//   cmd        command code (see above)
//   wr_data    WRITE byte, sampled at acceptance
//   rd_nack    READ acknowledge select, sampled at acceptance
//   rd_data    byte shifted in by READ (updates bit by bit)
//   ack_rcvd   SDA value sampled in the ninth bit of WRITE (0 = ACK)
//   timeout    last command aborted by the clock-stretch limit
//   done       one-cycle completion pulse
//   scl_i      SCL pad input
//   scl_o      SCL drive value (always 0; open drain)
//   scl_oen    SCL drive enable, active-low (1 = line released)
//   sda_i      SDA pad input
//   sda_o      SDA drive value (always 0; open drain)
//   sda_oen    SDA drive enable, active-low (1 = line released)
// ---------------------------------------------------------------------------
module i2c_byte_master #(
    parameter int CLK_DIV     = 36,
    parameter int STRETCH_MAX = 14318
) (
    input  logic       clk14,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_nack,
    output logic [7:0] rd_data,
    output logic       ack_rcvd,
    output logic       timeout,
    output logic       done,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_oen,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oen
);

    localparam int SW = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX + 1) : 1;

    localparam logic [15:0]   CNT_LOAD     = 16'(CLK_DIV - 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_MAX - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STOP,
        BIT,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_C,
        PH_D
    } phase_t;

    state_t          state;
    phase_t          phase;
    logic [15:0]     phase_cnt;
    logic [SW-1:0]   stretch_cnt;
    logic [3:0]      bit_idx;
    logic [7:0]      tx_shift;
    logic            is_read;
    logic            nack_q;

    logic            stretch_phase;
    logic            phase_last;
    logic            d_first;
    logic            next_sda_oen;

    // Both pads are open drain, so only the enables ever move.
    assign scl_o = 1'b0;
    assign sda_o = 1'b0;

    // The phase in which SCL has just been released and a slave may stretch.
    // For START and STOP, SCL is released in phase B. For a data bit, SCL is
    // released in phase C.
    always_comb begin
        stretch_phase = 1'b0;
        if (state == BIT) begin
            stretch_phase = (phase == PH_C);
        end else if ((state == START) || (state == STOP)) begin
            stretch_phase = (phase == PH_B);
        end
    end

    assign phase_last = (phase_cnt == 16'd0);

    // The phase counter is reloaded on entry to each phase. While it still
    // holds the reload value, the engine is in the first cycle of that phase.
    assign d_first = (state == BIT) && (phase == PH_D) && (phase_cnt == CNT_LOAD);

    // SDA enable for the next bit slot when the current slot ends.
    // Slot 8 is the acknowledge slot: a WRITE releases SDA so the slave can
    // answer, and a READ drives its ACK or releases SDA for a NACK.
    always_comb begin
        next_sda_oen = 1'b1;
        if (bit_idx == 4'd7) begin
            next_sda_oen = is_read ? nack_q : 1'b1;
        end else begin
            next_sda_oen = is_read ? 1'b1 : tx_shift[6];
        end
    end

    // Main engine: command acceptance, phase sequencing, stretch supervision
    // and the registered pad enables. Pad enables change only on phase
    // entry, so each phase's line levels are stable for the whole phase.
    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            state       <= IDLE;
            phase       <= PH_A;
            phase_cnt   <= 16'd0;
            stretch_cnt <= '0;
            bit_idx     <= 4'd0;
            tx_shift    <= 8'd0;
            is_read     <= 1'b0;
            nack_q      <= 1'b0;
            scl_oen     <= 1'b1;
            sda_oen     <= 1'b1;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            rd_data     <= 8'd0;
            ack_rcvd    <= 1'b1;
            timeout     <= 1'b0;
        end else begin
            done <= 1'b0;

            // Sample SDA once per bit, in the first cycle of phase D.
            if (d_first) begin
                if (is_read && !bit_idx[3]) begin
                    rd_data <= {rd_data[6:0], sda_i};
                end
                if (!is_read && (bit_idx == 4'd8)) begin
                    ack_rcvd <= sda_i;
                end
            end

            case (state)
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (cmd_valid) begin
                        // The cycle after acceptance is already phase A.
                        // Each command's phase-A line levels are set here.
                        cmd_ready   <= 1'b0;
                        timeout     <= 1'b0;
                        phase       <= PH_A;
                        phase_cnt   <= CNT_LOAD;
                        stretch_cnt <= '0;
                        bit_idx     <= 4'd0;
                        tx_shift    <= wr_data;
                        nack_q      <= rd_nack;
                        is_read     <= 1'b0;
                        case (cmd)
                            CMD_START: begin
                                state   <= START;
                                sda_oen <= 1'b1;
                            end
                            CMD_STOP: begin
                                state   <= STOP;
                                scl_oen <= 1'b0;
                                sda_oen <= 1'b0;
                            end
                            CMD_WRITE: begin
                                state   <= BIT;
                                scl_oen <= 1'b0;
                                sda_oen <= wr_data[7];
                            end
                            default: begin
                                state   <= BIT;
                                is_read <= 1'b1;
                                scl_oen <= 1'b0;
                                sda_oen <= 1'b1;
                            end
                        endcase
                    end
                end

                START, STOP, BIT: begin
                    if (stretch_phase && !scl_i) begin
                        // A slave is holding SCL low. The phase counter
                        // waits, and the stretch counter checks the limit.
                        if (stretch_cnt == STRETCH_LAST) begin
                            scl_oen   <= 1'b1;
                            sda_oen   <= 1'b1;
                            timeout   <= 1'b1;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            stretch_cnt <= stretch_cnt + SW'(1);
                        end
                    end else if (!phase_last) begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end else begin
                        phase_cnt   <= CNT_LOAD;
                        stretch_cnt <= '0;
                        case (phase)
                            PH_A: begin
                                phase <= PH_B;
                                if (state != BIT) begin
                                    scl_oen <= 1'b1;
                                end
                            end
                            PH_B: begin
                                phase <= PH_C;
                                if (state == BIT) begin
                                    scl_oen <= 1'b1;
                                end else if (state == START) begin
                                    // SDA falls while SCL is high.
                                    sda_oen <= 1'b0;
                                end
                            end
                            PH_C: begin
                                phase <= PH_D;
                                if (state == START) begin
                                    scl_oen <= 1'b0;
                                end else if (state == STOP) begin
                                    // SDA rises while SCL is high.
                                    sda_oen <= 1'b1;
                                end
                            end
                            default: begin
                                phase <= PH_A;
                                if ((state != BIT) || (bit_idx == 4'd8)) begin
                                    // A byte ends with SCL held low and SDA
                                    // released. This leaves the bus ready
                                    // for another byte, a repeated START
                                    // or a STOP.
                                    if (state == BIT) begin
                                        scl_oen <= 1'b0;
                                        sda_oen <= 1'b1;
                                    end
                                    done      <= 1'b1;
                                    cmd_ready <= 1'b1;
                                    state     <= FINISH;
                                end else begin
                                    bit_idx  <= bit_idx + 4'd1;
                                    tx_shift <= {tx_shift[6:0], 1'b0};
                                    scl_oen  <= 1'b0;
                                    sda_oen  <= next_sda_oen;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
